ras_stack: RTL
==============

Name: ras_stack

Overview:
- 8-entry circular return address stack (RAS) for the fetch predictor path.
- Sits beside the BTB in fetch stage 1. It supplies the predicted return target when the BTB marks a return, and records return addresses when the BTB marks a call.
- Exposes the top index and occupancy so the frontend can snapshot them into checkpoints.
- Restores that snapshot when the ROB reports a mispredict.

Parameters:
- RAS_ENTRIES, 8, stack depth; must be a power of 2.
- RAS_INDEX_WIDTH, $clog2(RAS_ENTRIES), width of the top pointer.
- RAS_TARGET_WIDTH, 31, width of a stored target, PC[31:1].

Ports:
- CLK  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- link_valid  in  1  fetch predicts a call this cycle: push.
- link_target  in  RAS_TARGET_WIDTH  return address to push, PC[31:1].
- ret_valid  in  1  fetch predicts a return this cycle: pop.
- ret_target  out  RAS_TARGET_WIDTH  current top entry, combinational from state.
- ras_empty  out  1  count == 0; ret_target is stale when this is high.
- ras_index  out  RAS_INDEX_WIDTH  current top pointer, for checkpointing.
- ras_count  out  RAS_INDEX_WIDTH+1  valid entries, 0..RAS_ENTRIES, for checkpointing.
- restore_valid  in  1  mispredict restore.
- restore_index  in  RAS_INDEX_WIDTH  checkpointed top pointer.
- restore_count  in  RAS_INDEX_WIDTH+1  checkpointed count.
- restore_link_valid  in  1  the mispredicted instruction is itself a call; push after restore.
- restore_link_target  in  RAS_TARGET_WIDTH  its return address.

Behaviour:
- State:
  - stack[RAS_ENTRIES] of RAS_TARGET_WIDTH bits.
  - top pointer `top`, RAS_INDEX_WIDTH bits, modular.
  - `count`, RAS_INDEX_WIDTH+1 bits, saturating.
- Reset (rst high at posedge):
  - all stack entries = 0, top = 0, count = 0.
  - Outputs after reset: ret_target = 0, ras_empty = 1, ras_index = 0, ras_count = 0.
  - Reset overrides every other input in that cycle.
- Outputs are combinational from state:
  - ret_target = stack[top].
  - ras_empty = (count == 0).
  - ras_index = top, ras_count = count.
- A pop's predicted target is the ret_target value in the same cycle ret_valid is high, i.e. zero latency. The pointer update takes effect next cycle.
- Priority, highest first: rst, then restore_valid, then the fetch link/ret actions.
- Fetch actions are ignored in any cycle where restore_valid = 1.
- Fetch actions (restore_valid = 0):
  - link only:
    - top <= top+1 (mod RAS_ENTRIES); stack[top+1] <= link_target.
    - count <= min(count+1, RAS_ENTRIES).
    - On overflow the oldest entry is silently overwritten.
  - ret only:
    - top <= top-1 (mod RAS_ENTRIES); count <= max(count-1, 0).
    - Popping when empty still moves top and leaves count at 0.
  - link and ret together (coroutine/tail-call):
    - stack[top] <= link_target; top and count unchanged.
  - neither: hold state.
- Restore (restore_valid = 1):
  - restore_link_valid = 0: top <= restore_index; count <= restore_count.
  - restore_link_valid = 1:
    - top <= restore_index+1; stack[restore_index+1] <= restore_link_target.
    - count <= min(restore_count+1, RAS_ENTRIES).
  - Stack contents are never restored. Entries overwritten on the wrong path stay corrupted; this is an accepted accuracy loss.
- restore_count > RAS_ENTRIES is illegal input. The verification bench asserts it never occurs.
- Pointer arithmetic wraps naturally in RAS_INDEX_WIDTH bits. count arithmetic uses RAS_INDEX_WIDTH+1 bits with explicit saturation at both ends.
- No handshake or backpressure: every asserted action is accepted in its cycle.

Decomposition:
- RAS_ENTRIES, RAS_INDEX_WIDTH and RAS_TARGET_WIDTH stay in core_types_pkg. The module takes them as parameter defaults.
- Add a packed typedef ras_checkpoint_t {index, count} to core_types_pkg. The checkpoint array uses it.
- No sub-module. The stack is a small flop array: 8x31 flops plus pointer and count.

Test Plan:
1. Reset, then idle -> ras_empty = 1, ras_index = 0, ras_count = 0, ret_target = 0.
2. Push 0x100, 0x200, 0x300 on consecutive cycles, then pop three times:
   - before the pops: ras_count = 3, ras_index = 3, ret_target = 0x300.
   - pops see ret_target 0x300, then 0x200, then 0x100.
   - final state: ras_count = 0, ras_empty = 1.
3. Overflow: push 10 distinct targets T0..T9:
   - ras_count saturates at 8; ras_index = 10 mod 8 = 2; ret_target = T9.
   - 8 pops return T9..T2; a 9th pop returns stale data with ras_empty = 1 and ras_count held at 0.
4. Simultaneous link+ret with top = 0x200, count = 2, link_target = 0x555:
   - next cycle ret_target = 0x555; ras_index and ras_count unchanged.
5. Restore:
   - capture index = 2, count = 2; push 0x777; then restore_valid with index 2, count 2 and fetch link_valid also asserted.
   - Required: fetch link is ignored; ras_index = 2, ras_count = 2.
   - Then restore with restore_link_valid = 1, target 0x999 -> ras_index = 3, ras_count = 3, ret_target = 0x999.
6. Reset mid-operation:
   - assert rst in the same cycle as link_valid and restore_valid.
   - Required: next cycle is the full reset state; a subsequent push of 0x42 gives ras_index = 1, ret_target = 0x42.

Source files
------------

// File: rtl/core_types_pkg.sv
// Shared frontend types and sizing constants.
//   RAS_ENTRIES       return address stack depth (power of 2)
//   RAS_INDEX_WIDTH   width of the RAS top pointer
//   RAS_TARGET_WIDTH  width of a stored return target, PC[31:1]
//   ras_checkpoint_t  {index, count} snapshot taken by fetch and restored on mispredict
//   ras_action_e      fetch-side action decoded from link/ret
package core_types_pkg;

  localparam int unsigned RAS_ENTRIES      = 8;
  localparam int unsigned RAS_INDEX_WIDTH  = $clog2(RAS_ENTRIES);
  localparam int unsigned RAS_TARGET_WIDTH = 31;

  typedef struct packed {
    logic [RAS_INDEX_WIDTH-1:0] index;
    logic [RAS_INDEX_WIDTH:0]   count;
  } ras_checkpoint_t;

  typedef enum logic [1:0] {
    RAS_HOLD    = 2'b00,
    RAS_PUSH    = 2'b01,
    RAS_POP     = 2'b10,
    RAS_REPLACE = 2'b11
  } ras_action_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return address stack for the fetch predictor path.
// Ports:
//   CLK, rst                 clock, synchronous active-high reset
//   link_valid/link_target   push a return address (predicted call)
//   ret_valid                pop (predicted return)
//   ret_target               top entry, combinational; stale when ras_empty
//   ras_empty                no valid entries
//   ras_index, ras_count     top pointer and occupancy for checkpointing
//   restore_*                mispredict restore of {index, count}, with optional
//                            push when the mispredicted instruction is a call
// Stack contents are never restored; only pointer and count are.
module ras_stack #(
  parameter int unsigned RAS_ENTRIES      = core_types_pkg::RAS_ENTRIES,
  parameter int unsigned RAS_INDEX_WIDTH  = $clog2(RAS_ENTRIES),
  parameter int unsigned RAS_TARGET_WIDTH = core_types_pkg::RAS_TARGET_WIDTH
) (
  input  logic                        CLK,
  input  logic                        rst,
  input  logic                        link_valid,
  input  logic [RAS_TARGET_WIDTH-1:0] link_target,
  input  logic                        ret_valid,
  output logic [RAS_TARGET_WIDTH-1:0] ret_target,
  output logic                        ras_empty,
  output logic [RAS_INDEX_WIDTH-1:0]  ras_index,
  output logic [RAS_INDEX_WIDTH:0]    ras_count,
  input  logic                        restore_valid,
  input  logic [RAS_INDEX_WIDTH-1:0]  restore_index,
  input  logic [RAS_INDEX_WIDTH:0]    restore_count,
  input  logic                        restore_link_valid,
  input  logic [RAS_TARGET_WIDTH-1:0] restore_link_target
);
  import core_types_pkg::*;

  localparam logic [RAS_INDEX_WIDTH:0]   FULL = (RAS_INDEX_WIDTH+1)'(RAS_ENTRIES);
  localparam logic [RAS_INDEX_WIDTH-1:0] ONE  = RAS_INDEX_WIDTH'(1);

  logic [RAS_TARGET_WIDTH-1:0] stack [RAS_ENTRIES];
  logic [RAS_INDEX_WIDTH-1:0]  top, top_nxt, wr_idx;
  logic [RAS_INDEX_WIDTH:0]    count, count_nxt;
  logic                        wr_en;
  logic [RAS_TARGET_WIDTH-1:0] wr_data;
  ras_action_e                 action;

  assign action = ras_action_e'({ret_valid, link_valid});

  always_comb begin
    top_nxt   = top;
    count_nxt = count;
    wr_en     = 1'b0;
    wr_idx    = top;
    wr_data   = link_target;
    if (restore_valid) begin
      // Restore wins over fetch; fetch link/ret are dropped this cycle.
      if (restore_link_valid) begin
        top_nxt   = restore_index + ONE;
        wr_en     = 1'b1;
        wr_idx    = restore_index + ONE;
        wr_data   = restore_link_target;
        count_nxt = (restore_count >= FULL) ? FULL : restore_count + 1'b1;
      end else begin
        top_nxt   = restore_index;
        count_nxt = restore_count;
      end
    end else begin
      unique case (action)
        RAS_PUSH: begin
          // Full stack: the oldest entry is overwritten, count stays saturated.
          top_nxt   = top + ONE;
          wr_en     = 1'b1;
          wr_idx    = top + ONE;
          count_nxt = (count >= FULL) ? FULL : count + 1'b1;
        end
        RAS_POP: begin
          // Pointer moves even when empty; count floors at zero.
          top_nxt   = top - ONE;
          count_nxt = (count == '0) ? '0 : count - 1'b1;
        end
        RAS_REPLACE: begin
          wr_en = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      for (int unsigned i = 0; i < RAS_ENTRIES; i++) stack[i] <= '0;
      top   <= '0;
      count <= '0;
    end else begin
      top   <= top_nxt;
      count <= count_nxt;
      if (wr_en) stack[wr_idx] <= wr_data;
    end
  end

  assign ret_target = stack[top];
  assign ras_empty  = (count == '0);
  assign ras_index  = top;
  assign ras_count  = count;

endmodule
